// File: rtl/proc_mc.sv
// Multi-cycle RV32I-subset core: fetch/decode/execute/writeback FSM driving an external
// multi-cycle ALU, with a writable instruction memory, start/halt control and debug reads.
module proc_mc #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned BOOT_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic                          alu_in_valid,
    output logic [XLEN-1:0]               alu_a,
    output logic [XLEN-1:0]               alu_b,
    output logic [2:0]                    alu_funct3,
    output logic                          alu_arith,
    input  logic [XLEN-1:0]               alu_result,
    input  logic                          alu_out_valid,
    output logic [XLEN-1:0]               pc,
    output logic                          busy,
    output logic                          halted,
    output logic                          illegal,
    output logic                          retire,
    output logic [31:0]                   instret,
    input  logic [4:0]                    dbg_raddr,
    output logic [XLEN-1:0]               dbg_rdata
);

    localparam int unsigned     AW         = $clog2(IMEM_DEPTH);
    localparam int unsigned     RW         = $clog2(NUM_REGS);
    localparam logic [5:0]      NREGS      = 6'(NUM_REGS);
    localparam logic [XLEN-1:0] BOOT_PC    = XLEN'(BOOT_ADDR);
    localparam logic [6:0]      OPC_OP     = 7'h33;
    localparam logic [6:0]      OPC_OPIMM  = 7'h13;
    localparam logic [6:0]      OPC_LUI    = 7'h37;
    localparam logic [6:0]      OPC_BRANCH = 7'h63;
    localparam logic [31:0]     EBREAK     = 32'h0010_0073;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StWait, StWb, StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]      alu_f3_q, alu_f3_d;
    logic            alu_arith_q, alu_arith_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [31:0]     instret_q, instret_d;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] regs [NUM_REGS];

    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    function automatic logic reg_ok(input logic [4:0] r);
        return {1'b0, r} < NREGS;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic            f7_ok, op_legal, opimm_legal, lui_legal, br_legal, is_ebreak;
    logic [XLEN-1:0] imm_i, imm_b, lui_val, rs1_val, rs2_val, pc_plus4, next_pc;
    logic            br_taken;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    // funct7 0x20 only selects SUB (f3=000) and SRA (f3=101).
    assign f7_ok = (funct7 == 7'h00) ||
                   (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    assign op_legal = (opcode == OPC_OP) && f7_ok && reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd);
    assign opimm_legal = (opcode == OPC_OPIMM) && reg_ok(rs1) && reg_ok(rd) &&
                         ((funct3 != 3'b001 && funct3 != 3'b101) || f7_ok);
    assign lui_legal = (opcode == OPC_LUI) && reg_ok(rd);
    assign br_legal  = (opcode == OPC_BRANCH) && funct3 != 3'b010 && funct3 != 3'b011 &&
                       reg_ok(rs1) && reg_ok(rs2);
    assign is_ebreak = (instr_q == EBREAK);

    assign imm_i   = sext32({{20{instr_q[31]}}, instr_q[31:20]});
    assign imm_b   = sext32({{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                             instr_q[11:8], 1'b0});
    assign lui_val = sext32({instr_q[31:12], 12'b0});

    always_comb begin
        rs1_val   = '0;
        rs2_val   = '0;
        dbg_rdata = '0;
        if (rs1 != 5'd0 && reg_ok(rs1)) rs1_val = regs[rs1[RW-1:0]];
        if (rs2 != 5'd0 && reg_ok(rs2)) rs2_val = regs[rs2[RW-1:0]];
        if (dbg_raddr != 5'd0 && reg_ok(dbg_raddr)) dbg_rdata = regs[dbg_raddr[RW-1:0]];
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + XLEN'(4);
    assign next_pc  = (opcode == OPC_BRANCH && br_taken) ? pc_q + imm_b : pc_plus4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_f3_d    = alu_f3_q;
        alu_arith_d = alu_arith_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        instret_d   = instret_q;
        retire      = 1'b0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d      = BOOT_PC;
                    illegal_d = 1'b0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                instr_d = imem[pc_q[AW+1:2]];
                state_d = StDecode;
            end
            StDecode: begin
                if (is_ebreak) begin
                    retire    = 1'b1;
                    instret_d = instret_q + 32'd1;
                    state_d   = StHalt;
                end else if (op_legal || opimm_legal) begin
                    alu_a_d     = rs1_val;
                    alu_f3_d    = funct3;
                    alu_b_d     = imm_i;
                    alu_arith_d = 1'b0;
                    if (opcode == OPC_OP) begin
                        // SUB is issued to the ALU as an add of the negated operand.
                        alu_b_d     = (funct3 == 3'b000 && funct7[5]) ? -rs2_val : rs2_val;
                        alu_arith_d = funct7[5];
                    end else if (funct3 == 3'b101) begin
                        alu_arith_d = funct7[5];
                    end
                    state_d = StExec;
                end else if (lui_legal || br_legal) begin
                    state_d = StWb;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end
            end
            StExec: state_d = StWait;
            StWait: begin
                if (alu_out_valid) begin
                    result_d = alu_result;
                    state_d  = StWb;
                end
            end
            StWb: begin
                if (next_pc[1:0] != 2'b00) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    retire    = 1'b1;
                    instret_d = instret_q + 32'd1;
                    pc_d      = next_pc;
                    rf_we     = (opcode != OPC_BRANCH) && (rd != 5'd0);
                    rf_wdata  = (opcode == OPC_LUI) ? lui_val : result_q;
                    state_d   = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= BOOT_PC;
            instr_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f3_q    <= '0;
            alu_arith_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f3_q    <= alu_f3_d;
            alu_arith_q <= alu_arith_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            instret_q   <= instret_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[rd[RW-1:0]] <= rf_wdata;
        end
    end

    // Program loading is only allowed while the core is not executing.
    always_ff @(posedge clk) begin
        if (imem_we && (state_q == StIdle || state_q == StHalt)) imem[imem_waddr] <= imem_wdata;
    end

    assign alu_in_valid = (state_q == StExec);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_funct3   = alu_f3_q;
    assign alu_arith    = alu_arith_q;
    assign pc           = pc_q;
    assign busy         = (state_q != StIdle) && (state_q != StHalt);
    assign halted       = (state_q == StHalt);
    assign illegal      = illegal_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_proc_mc.sv
// Directed bench for proc_mc: programs are loaded and run, expected architectural results
// are queued on a scoreboard at load time and compared once the core halts.
module tb_proc_mc;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam int K_REG = 0, K_INSTRET = 1, K_ILLEGAL = 2, K_HALTED = 3, K_PC = 4, K_GAP = 5;
    localparam int K_RETDBL = 6, K_TAKEN = 7, K_RETN = 8, K_BUSY = 9, K_ALUIN = 10;
    localparam int K_RETIRE = 11, K_REG16 = 12, K_ILL16 = 13, K_HALT16 = 14, K_INST16 = 15;
    localparam int K_PC16 = 16;

    logic        clk = 1'b0;
    logic        rst, start, start16, imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;

    logic        alu_in_valid, alu_arith, alu_out_valid, busy, halted, illegal, retire;
    logic [31:0] alu_a, alu_b, alu_result, pc, instret, dbg_rdata;
    logic [2:0]  alu_funct3;
    logic [4:0]  dbg_raddr;

    logic        alu16_in_valid, alu16_arith, alu16_out_valid, busy16, halted16, illegal16;
    logic        retire16;
    logic [31:0] alu16_a, alu16_b, alu16_result, pc16, instret16, dbg16_rdata;
    logic [2:0]  alu16_funct3;
    logic [4:0]  dbg16_raddr;

    proc_mc u_dut (
        .clk(clk), .rst(rst), .start(start), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .alu_in_valid(alu_in_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_funct3(alu_funct3), .alu_arith(alu_arith), .alu_result(alu_result),
        .alu_out_valid(alu_out_valid), .pc(pc), .busy(busy), .halted(halted),
        .illegal(illegal), .retire(retire), .instret(instret), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
    );

    proc_mc #(.NUM_REGS(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .alu_in_valid(alu16_in_valid), .alu_a(alu16_a),
        .alu_b(alu16_b), .alu_funct3(alu16_funct3), .alu_arith(alu16_arith),
        .alu_result(alu16_result), .alu_out_valid(alu16_out_valid), .pc(pc16),
        .busy(busy16), .halted(halted16), .illegal(illegal16), .retire(retire16),
        .instret(instret16), .dbg_raddr(dbg16_raddr), .dbg_rdata(dbg16_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic ar);
        logic signed [31:0] sa;
        logic [31:0]        r;
        sa = a;
        case (f3)
            3'd0: r = a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (ar) r = sa >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // ALU model with programmable latency, reset together with the core.
    int          alu_lat;
    int          alu_cnt;
    logic        alu_pend;
    logic [31:0] alu_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_valid <= 1'b0;
            alu_result    <= '0;
            alu_pend      <= 1'b0;
            alu_cnt       <= 0;
            alu_hold      <= '0;
        end else begin
            alu_out_valid <= 1'b0;
            if (alu_in_valid) begin
                if (alu_lat <= 1) begin
                    alu_out_valid <= 1'b1;
                    alu_result    <= alu_fn(alu_a, alu_b, alu_funct3, alu_arith);
                end else begin
                    alu_pend <= 1'b1;
                    alu_cnt  <= alu_lat - 1;
                    alu_hold <= alu_fn(alu_a, alu_b, alu_funct3, alu_arith);
                end
            end else if (alu_pend) begin
                if (alu_cnt == 1) begin
                    alu_out_valid <= 1'b1;
                    alu_result    <= alu_hold;
                    alu_pend      <= 1'b0;
                end else begin
                    alu_cnt <= alu_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu16_out_valid <= 1'b0;
            alu16_result    <= '0;
        end else begin
            alu16_out_valid <= alu16_in_valid;
            alu16_result    <= alu_fn(alu16_a, alu16_b, alu16_funct3, alu16_arith);
        end
    end

    // Retire timing and taken-branch monitor.
    int          cyc = 0, rt_double = 0, taken = 0;
    int          rt_cyc[$];
    logic        prev_retire = 1'b0, prev_busy = 1'b0;
    logic [31:0] last_pc = '0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (retire) begin
            rt_cyc.push_back(cyc);
            if (prev_retire) rt_double = rt_double + 1;
        end
        prev_retire = retire;
        if (prev_busy && busy && pc != last_pc && pc != last_pc + 32'd4) taken = taken + 1;
        prev_busy = busy;
        last_pc   = pc;
    end

    int          n_asserts = 0, n_fails = 0, inst_exp = 0;
    string       sb_tag[$];
    int          sb_kind[$], sb_idx[$];
    logic [31:0] sb_exp[$];
    logic [31:0] prog[$];

    task automatic push(input string tag, input int kind, input int idx, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_idx.push_back(idx);
        sb_exp.push_back(v);
    endtask

    task automatic check_sb();
        string       tag;
        int          k, idx;
        logic [31:0] e, obs;
        #1;
        while (sb_exp.size() > 0) begin
            tag = sb_tag.pop_front();
            k   = sb_kind.pop_front();
            idx = sb_idx.pop_front();
            e   = sb_exp.pop_front();
            case (k)
                K_REG:     begin dbg_raddr = idx[4:0]; #1; obs = dbg_rdata; end
                K_REG16:   begin dbg16_raddr = idx[4:0]; #1; obs = dbg16_rdata; end
                K_INSTRET: obs = instret;
                K_ILLEGAL: obs = {31'b0, illegal};
                K_HALTED:  obs = {31'b0, halted};
                K_PC:      obs = pc;
                K_GAP:     obs = (rt_cyc.size() >= 2) ? 32'(rt_cyc[1] - rt_cyc[0]) : '1;
                K_RETDBL:  obs = 32'(rt_double);
                K_TAKEN:   obs = 32'(taken);
                K_RETN:    obs = 32'(rt_cyc.size());
                K_BUSY:    obs = {31'b0, busy};
                K_ALUIN:   obs = {31'b0, alu_in_valid};
                K_RETIRE:  obs = {31'b0, retire};
                K_ILL16:   obs = {31'b0, illegal16};
                K_HALT16:  obs = {31'b0, halted16};
                K_INST16:  obs = instret16;
                K_PC16:    obs = pc16;
                default:   obs = 'x;
            endcase
            n_asserts++;
            assert (obs === e) else begin
                n_fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clk);
            imem_we    = 1'b1;
            imem_waddr = 10'(i);
            imem_wdata = prog[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic run(input bit inject, input bit both);
        bit done;
        done = 1'b0;
        @(negedge clk);
        rt_cyc.delete();
        rt_double = 0;
        taken     = 0;
        start     = 1'b1;
        start16   = both;
        @(negedge clk);
        start   = 1'b0;
        start16 = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (inject && i == 2) begin
                imem_we    = 1'b1;
                imem_waddr = 10'd1;
                imem_wdata = EBREAK;
            end else begin
                imem_we = 1'b0;
            end
            @(negedge clk);
            done = halted && (!both || halted16);
        end
        imem_we = 1'b0;
        n_asserts++;
        assert (done) else begin
            n_fails++;
            $error("FAIL run_timeout: halted observed %0b expected 1", halted);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] btype(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; start16 = 1'b0; imem_we = 1'b0;
        imem_waddr = '0; imem_wdata = '0; dbg_raddr = '0; dbg16_raddr = '0; alu_lat = 1;
        repeat (2) @(negedge clk);
        push("rst_busy", K_BUSY, 0, 32'd0);
        push("rst_halted", K_HALTED, 0, 32'd0);
        push("rst_illegal", K_ILLEGAL, 0, 32'd0);
        push("rst_instret", K_INSTRET, 0, 32'd0);
        push("rst_pc", K_PC, 0, 32'd0);
        push("rst_alu_in_valid", K_ALUIN, 0, 32'd0);
        push("rst_retire", K_RETIRE, 0, 32'd0);
        check_sb();
        rst = 1'b0;

        // Basic addi chain with ALU latency 1, then 5.
        for (int pass = 0; pass < 2; pass++) begin
            alu_lat = (pass == 0) ? 1 : 5;
            prog = '{addi(5'd1, 5'd0, 12'd5), addi(5'd2, 5'd1, 12'hFF9), EBREAK};
            load_prog();
            inst_exp += 3;
            push("addi_x1", K_REG, 1, 32'd5);
            push("addi_x2", K_REG, 2, 32'hFFFF_FFFE);
            push("addi_halted", K_HALTED, 0, 32'd1);
            push("addi_illegal", K_ILLEGAL, 0, 32'd0);
            push("addi_instret", K_INSTRET, 0, 32'(inst_exp));
            push("addi_pc", K_PC, 0, 32'd8);
            push("addi_gap", K_GAP, 0, 32'(4 + alu_lat));
            push("retire_width", K_RETDBL, 0, 32'd0);
            push("retire_count", K_RETN, 0, 32'd3);
            run(1'b0, 1'b0);
            check_sb();
        end

        // ALU op mix with x1=-8, x2=3, plus LUI.
        alu_lat = 2;
        prog = '{addi(5'd1, 5'd0, 12'hFF8), addi(5'd2, 5'd0, 12'd3),
                 rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),
                 rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd5), rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd6),
                 rtype(7'h20, 5'd2, 5'd1, 3'b101, 5'd7), {20'h12345, 5'd8, 7'h37}, EBREAK};
        load_prog();
        inst_exp += 9;
        push("add", K_REG, 3, 32'hFFFF_FFFB);
        push("sub", K_REG, 4, 32'hFFFF_FFF5);
        push("slt", K_REG, 5, 32'd1);
        push("sltu", K_REG, 6, 32'd0);
        push("sra", K_REG, 7, 32'hFFFF_FFFF);
        push("lui", K_REG, 8, 32'h1234_5000);
        push("ops_instret", K_INSTRET, 0, 32'(inst_exp));
        run(1'b0, 1'b0);
        check_sb();

        // Countdown loop: two taken bne, one fall-through.
        alu_lat = 1;
        prog = '{addi(5'd1, 5'd0, 12'd3), addi(5'd1, 5'd1, 12'hFFF),
                 btype(13'h1FFC, 5'd0, 5'd1, 3'b001), EBREAK};
        load_prog();
        inst_exp += 8;
        push("loop_x1", K_REG, 1, 32'd0);
        push("loop_instret", K_INSTRET, 0, 32'(inst_exp));
        push("loop_taken", K_TAKEN, 0, 32'd2);
        push("loop_pc", K_PC, 0, 32'd12);
        push("loop_illegal", K_ILLEGAL, 0, 32'd0);
        run(1'b0, 1'b0);
        check_sb();

        // All-ones word and misaligned branch target both halt as illegal without retiring.
        for (int pass = 0; pass < 2; pass++) begin
            prog = '{(pass == 0) ? 32'hFFFF_FFFF : btype(13'd2, 5'd0, 5'd0, 3'b000)};
            load_prog();
            push("ill_halted", K_HALTED, 0, 32'd1);
            push("ill_flag", K_ILLEGAL, 0, 32'd1);
            push("ill_instret", K_INSTRET, 0, 32'(inst_exp));
            push("ill_retires", K_RETN, 0, 32'd0);
            push("ill_pc", K_PC, 0, 32'd0);
            run(1'b0, 1'b0);
            check_sb();
        end

        // A restart clears the sticky illegal flag.
        prog = '{EBREAK};
        load_prog();
        inst_exp += 1;
        push("restart_illegal", K_ILLEGAL, 0, 32'd0);
        push("restart_instret", K_INSTRET, 0, 32'(inst_exp));
        run(1'b0, 1'b0);
        check_sb();

        // An imem write while busy must not land.
        alu_lat = 5;
        prog = '{addi(5'd10, 5'd0, 12'd7), addi(5'd11, 5'd0, 12'd9), EBREAK};
        load_prog();
        inst_exp += 3;
        push("busy_we_x10", K_REG, 10, 32'd7);
        push("busy_we_x11", K_REG, 11, 32'd9);
        push("busy_we_instret", K_INSTRET, 0, 32'(inst_exp));
        run(1'b1, 1'b0);
        check_sb();

        // Reset while waiting on the ALU.
        prog = '{addi(5'd12, 5'd0, 12'd1), EBREAK};
        load_prog();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (alu_in_valid) seen = 1'b1;
            else @(negedge clk);
        end
        n_asserts++;
        assert (seen) else begin
            n_fails++;
            $error("FAIL exec_timeout: alu_in_valid observed 0 expected 1");
        end
        repeat (2) @(negedge clk);
        push("wait_busy", K_BUSY, 0, 32'd1);
        check_sb();
        rst = 1'b1;
        inst_exp = 0;
        push("rstw_busy", K_BUSY, 0, 32'd0);
        push("rstw_halted", K_HALTED, 0, 32'd0);
        push("rstw_x2", K_REG, 2, 32'd0);
        push("rstw_x7", K_REG, 7, 32'd0);
        push("rstw_x8", K_REG, 8, 32'd0);
        push("rstw_instret", K_INSTRET, 0, 32'd0);
        push("rstw_pc", K_PC, 0, 32'd0);
        check_sb();
        @(negedge clk);
        rst = 1'b0;

        // Same program on the 32- and 16-register cores: x20 is illegal only on the latter.
        alu_lat = 1;
        prog = '{addi(5'd5, 5'd0, 12'd11), addi(5'd20, 5'd0, 12'd1), EBREAK};
        load_prog();
        inst_exp += 3;
        push("r32_x5", K_REG, 5, 32'd11);
        push("r32_x20", K_REG, 20, 32'd1);
        push("r32_illegal", K_ILLEGAL, 0, 32'd0);
        push("r32_instret", K_INSTRET, 0, 32'(inst_exp));
        push("r16_x5", K_REG16, 5, 32'd11);
        push("r16_x20", K_REG16, 20, 32'd0);
        push("r16_illegal", K_ILL16, 0, 32'd1);
        push("r16_halted", K_HALT16, 0, 32'd1);
        push("r16_instret", K_INST16, 0, 32'd1);
        push("r16_pc", K_PC16, 0, 32'd4);
        run(1'b0, 1'b1);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
